// File: rtl/aes_subbytes_seq.sv
// AES SubBytes sequencer: captures a 128-bit state, pushes it through NUM_SBOX
// shared S-boxes one byte group per cycle, then holds the result on a valid/ready port.

module aes_sbox_usuba (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform.
  always_comb begin
    sq  = gmul(a_i, a_i);
    inv = sq;
    for (int unsigned i = 0; i < 6; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    y_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_subbytes_seq #(
  parameter int unsigned NUM_SBOX = 4,
  localparam int unsigned PASSES  = 16 / NUM_SBOX,
  localparam int unsigned CNT_W   = (PASSES > 1) ? $clog2(PASSES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_state,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_state,
  output logic             busy,
  output logic [CNT_W-1:0] pass_idx
);

  localparam int unsigned GW     = 8 * NUM_SBOX;
  localparam int unsigned LOG_GW = 3 + $clog2(NUM_SBOX);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PASSES - 1);

  if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 &&
      NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
    $error("aes_subbytes_seq: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [127:0]     cap_q;
  logic [127:0]     out_q;
  logic [CNT_W-1:0] pass_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [6:0]       base;
  logic [GW-1:0]    grp_in;
  logic [GW-1:0]    grp_out;

  assign base   = 7'(pass_q) << LOG_GW;
  assign grp_in = cap_q[base +: GW];

  for (genvar j = 0; j < NUM_SBOX; j++) begin : g_sbox
    aes_sbox_usuba u_sbox (
      .a_i (grp_in[8*j +: 8]),
      .y_o (grp_out[8*j +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cap_q       <= '0;
      out_q       <= '0;
      pass_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cap_q      <= in_state;
            pass_q     <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          out_q[base +: GW] <= grp_out;
          if (pass_q == LAST) begin
            pass_q      <= '0;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            pass_q <= pass_q + CNT_W'(1);
          end
        end
        DONE: begin
          // in_ready rises only after the consume edge, never in the same cycle.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = out_q;
  assign pass_idx  = pass_q;

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Directed bench for aes_subbytes_seq; five instances (NUM_SBOX=1,2,4,8,16) share inputs.

module tb_aes_subbytes_seq;

  localparam logic [127:0] FIPS_IN  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] FIPS_OUT = 128'h76abd7fe2b670130c56f6bf27b777c63;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_state;
  logic         out_ready;

  logic         ov [5];
  logic         ir [5];
  logic         bz [5];
  logic [127:0] os [5];
  logic [3:0]   pi [5];

  int total;
  int bad;
  int cyc;

  logic [7:0] sbox_tbl [256];

  for (genvar k = 0; k < 5; k++) begin : g_dut
    localparam int NS = 1 << k;
    localparam int P  = 16 / NS;
    localparam int CW = (P > 1) ? $clog2(P) : 1;
    logic [CW-1:0] pidx;
    aes_subbytes_seq #(.NUM_SBOX(NS)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (ir[k]),
      .in_state  (in_state),
      .out_valid (ov[k]),
      .out_ready (out_ready),
      .out_state (os[k]),
      .busy      (bz[k]),
      .pass_idx  (pidx)
    );
    assign pi[k] = 4'(pidx);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_state  = '0;
    tick;
    rst_n = 1'b1;
  endtask

  function automatic logic [127:0] sb_model(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_tbl[x[8*i +: 8]];
    return r;
  endfunction

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_state  = FIPS_IN;
    out_ready = 1'b0;
    tick;
    tick;
    for (int k = 0; k < 5; k++) begin
      total += 5;
      if (ov[k] !== 1'b0) begin bad++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, ov[k]); end
      if (ir[k] !== 1'b1) begin bad++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, ir[k]); end
      if (bz[k] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d]: got %b want 0", k, bz[k]); end
      if (os[k] !== 128'h0) begin bad++; $display("FAIL reset_out_state[%0d]: got %h want 0", k, os[k]); end
      if (pi[k] !== 4'd0) begin bad++; $display("FAIL reset_pass_idx[%0d]: got %0d want 0", k, pi[k]); end
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_fips_sweep;
    int p;
    do_reset;
    in_state = FIPS_IN;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int c = 0; c <= 17; c++) begin
      for (int k = 0; k < 5; k++) begin
        p = 16 >> k;
        total += 4;
        if (ov[k] !== (c >= p)) begin bad++; $display("FAIL sweep_out_valid[%0d] c=%0d: got %b want %b", k, c, ov[k], c >= p); end
        if (pi[k] !== ((c < p) ? 4'(c) : 4'd0)) begin bad++; $display("FAIL sweep_pass_idx[%0d] c=%0d: got %0d want %0d", k, c, pi[k], (c < p) ? c : 0); end
        if (bz[k] !== 1'b1) begin bad++; $display("FAIL sweep_busy[%0d] c=%0d: got %b want 1", k, c, bz[k]); end
        if (ir[k] !== 1'b0) begin bad++; $display("FAIL sweep_in_ready[%0d] c=%0d: got %b want 0", k, c, ir[k]); end
        if (c >= p) begin
          total++;
          if (os[k] !== FIPS_OUT) begin bad++; $display("FAIL sweep_out_state[%0d] c=%0d: got %h want %h", k, c, os[k], FIPS_OUT); end
        end
      end
      if (c < 17) tick;
    end
    in_valid  = 1'b1;
    in_state  = '1;
    out_ready = 1'b1;
    tick;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total += 3;
      if (ov[k] !== 1'b0) begin bad++; $display("FAIL consume_out_valid[%0d]: got %b want 0", k, ov[k]); end
      if (bz[k] !== 1'b0) begin bad++; $display("FAIL consume_busy[%0d]: got %b want 0", k, bz[k]); end
      if (ir[k] !== 1'b1) begin bad++; $display("FAIL consume_in_ready[%0d]: got %b want 1", k, ir[k]); end
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    in_state = '0;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    in_valid = 1'b1;
    in_state = '1;
    for (int i = 0; i < 10; i++) begin
      total += 3;
      if (ov[2] !== 1'b1) begin bad++; $display("FAIL bp_out_valid i=%0d: got %b want 1", i, ov[2]); end
      if (os[2] !== {16{8'h63}}) begin bad++; $display("FAIL bp_out_state i=%0d: got %h want %h", i, os[2], {16{8'h63}}); end
      if (ir[2] !== 1'b0) begin bad++; $display("FAIL bp_in_ready i=%0d: got %b want 0", i, ir[2]); end
      tick;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick;
    out_ready = 1'b0;
    total += 3;
    if (ir[2] !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready: got %b want 1", ir[2]); end
    if (ov[2] !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid: got %b want 0", ov[2]); end
    if (bz[2] !== 1'b0) begin bad++; $display("FAIL bp_release_busy: got %b want 0", bz[2]); end
    tick;
    total++;
    if (bz[2] !== 1'b0) begin bad++; $display("FAIL bp_second_ignored_busy: got %b want 0", bz[2]); end
  endtask

  task automatic test_edge_bytes;
    do_reset;
    in_state = {8{8'hff, 8'h53}};
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (16) tick;
    for (int k = 0; k < 5; k++) begin
      total += 2;
      if (ov[k] !== 1'b1) begin bad++; $display("FAIL edge_out_valid[%0d]: got %b want 1", k, ov[k]); end
      if (os[k] !== {8{8'h16, 8'hed}}) begin bad++; $display("FAIL edge_out_state[%0d]: got %h want %h", k, os[k], {8{8'h16, 8'hed}}); end
    end
  endtask

  task automatic test_reset_mid_run;
    do_reset;
    in_state = FIPS_IN;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (7) tick;
    total++;
    if (pi[0] !== 4'd7) begin bad++; $display("FAIL midrun_pass_idx: got %0d want 7", pi[0]); end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    total += 5;
    if (ov[0] !== 1'b0) begin bad++; $display("FAIL midrun_out_valid: got %b want 0", ov[0]); end
    if (os[0] !== 128'h0) begin bad++; $display("FAIL midrun_out_state: got %h want 0", os[0]); end
    if (ir[0] !== 1'b1) begin bad++; $display("FAIL midrun_in_ready: got %b want 1", ir[0]); end
    if (bz[0] !== 1'b0) begin bad++; $display("FAIL midrun_busy: got %b want 0", bz[0]); end
    if (pi[0] !== 4'd0) begin bad++; $display("FAIL midrun_pass_idx_clr: got %0d want 0", pi[0]); end
    in_state = {8{8'hff, 8'h53}};
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (15) tick;
    total++;
    if (ov[0] !== 1'b0) begin bad++; $display("FAIL midrun_early_valid: got %b want 0", ov[0]); end
    tick;
    total += 2;
    if (ov[0] !== 1'b1) begin bad++; $display("FAIL midrun_final_valid: got %b want 1", ov[0]); end
    if (os[0] !== {8{8'h16, 8'hed}}) begin bad++; $display("FAIL midrun_final_state: got %h want %h", os[0], {8{8'h16, 8'hed}}); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] s;
    logic [127:0] exp_s;
    int           acc_cyc;
    int           prev_acc;
    bit           got;
    logic         was_ready;
    do_reset;
    out_ready = 1'b1;
    prev_acc  = -1;
    for (int n = 0; n < 100; n++) begin
      s        = {$urandom, $urandom, $urandom, $urandom};
      in_state = s;
      in_valid = 1'b1;
      got      = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        was_ready = ir[2];
        tick;
        if (was_ready) got = 1'b1;
      end
      total++;
      if (!got) begin bad++; $display("FAIL b2b_accept_timeout n=%0d: got none want accept", n); break; end
      acc_cyc = cyc;
      if (prev_acc >= 0) begin
        total++;
        if (acc_cyc - prev_acc != 6) begin bad++; $display("FAIL b2b_period n=%0d: got %0d want 6", n, acc_cyc - prev_acc); end
      end
      prev_acc = acc_cyc;
      exp_s    = sb_model(s);
      got      = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        tick;
        if (ov[2] === 1'b1) got = 1'b1;
      end
      total++;
      if (!got) begin bad++; $display("FAIL b2b_valid_timeout n=%0d: got none want out_valid", n); break; end
      total += 2;
      if (cyc - acc_cyc != 4) begin bad++; $display("FAIL b2b_latency n=%0d: got %0d want 4", n, cyc - acc_cyc); end
      if (os[2] !== exp_s) begin bad++; $display("FAIL b2b_data n=%0d: got %h want %h", n, os[2], exp_s); end
    end
    in_valid  = 1'b0;
    tick;
    out_ready = 1'b0;
    tick;
  endtask

  initial begin
    sbox_tbl = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    total     = 0;
    bad       = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    out_ready = 1'b0;

    test_reset;
    test_fips_sweep;
    test_backpressure;
    test_edge_bytes;
    test_reset_mid_run;
    test_back_to_back;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_subbytes_seq.md
Name: aes_subbytes_seq

Overview:
Sequencer that applies AES SubBytes to a full 128-bit state. It time-shares NUM_SBOX instances of the combinational aes_sbox_usuba block across the 16 state bytes. The block captures a state through a valid/ready input handshake and feeds one byte group per cycle through the shared S-boxes. It then presents the 128-bit result on a valid/ready output handshake. It sits between the AES round-state register and the ShiftRows/MixColumns stage, so the S-box datapath count can be swept for PIM synthesis area/latency studies.

Parameters:
NUM_SBOX, 4, number of aes_sbox_usuba instances; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
PASSES, 16/NUM_SBOX (localparam), cycles spent in RUN per block.
CNT_W, max(1,$clog2(PASSES)) (localparam), width of the pass counter.

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  in_state is valid
in_ready  output  1  block can accept a state
in_state  input  128  input state; byte i = in_state[8i+7:8i]
out_valid  output  1  out_state is valid
out_ready  input  1  downstream accepts out_state
out_state  output  128  SubBytes result; byte i = sbox(in byte i)
busy  output  1  high in RUN or DONE
pass_idx  output  CNT_W  current group index during RUN, else 0

Behaviour:
- Reset: sampled at a clk edge with rst_n=0. Forces state=IDLE, pass_idx=0, out_valid=0, busy=0, in_ready=1 after that edge. out_state and the internal capture register are cleared to 0. Reset mid-operation abandons the block; no partial result is ever presented.
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid&in_ready at an edge: capture in_state, clear pass_idx, go to RUN.
  - RUN: in_ready=0, busy=1. Each cycle the S-box instances process group g=pass_idx, i.e. bytes g*NUM_SBOX .. g*NUM_SBOX+NUM_SBOX-1 of the captured state. Instance j handles byte g*NUM_SBOX+j. Results are written into the same byte positions of out_state at the edge. Groups run in ascending order. If pass_idx==PASSES-1: go to DONE and reset pass_idx to 0; otherwise increment pass_idx. With NUM_SBOX=16, RUN lasts exactly one cycle.
  - DONE: out_valid=1, busy=1, in_ready=0. out_state is held stable while out_valid=1 and out_ready=0. On out_valid&out_ready at an edge: go to IDLE and clear out_valid.
- Latency: out_valid rises PASSES cycles after the accepting edge. Minimum block period is PASSES+2 cycles with out_ready tied high. There is no same-cycle accept on the output-consume edge; in_ready rises the cycle after.
- in_valid while not in IDLE is ignored. in_state may change freely after capture.
- out_ready while not in DONE is ignored.
- Bytes not yet written during RUN keep their previous out_state values. These are not observable because out_valid=0.
- Datapath: pure byte substitution, no arithmetic. S-box outputs are registered; no combinational path from in_state to out_state.

Test Plan:
- Reset then FIPS-197 vector, NUM_SBOX=4: in_state=128'h0f0e0d0c0b0a09080706050403020100 accepted at edge 0 -> out_valid at edge 4, out_state=128'h76abd7fe2b670130c56f6bf27b777c63; busy=1 from edge 0 until the consume edge.
- Parameter sweep NUM_SBOX=1,2,8,16 with the same vector -> identical out_state. out_valid appears 16/8/2/1 cycles after accept, and pass_idx counts 0..PASSES-1.
- Backpressure: in_state=all 8'h00, out_ready held low 10 cycles -> out_state=all 8'h63 stable and out_valid=1 throughout. in_ready=0, and a second in_valid is ignored. After out_ready=1, in_ready=1 on the following cycle.
- Edge bytes: in_state bytes 0x53 and 0xff alternating -> output bytes 0xed and 0x16 respectively at every position.
- Reset mid-RUN with NUM_SBOX=1: rst_n=0 at pass_idx=7 -> next cycle IDLE, out_valid=0, out_state=0. A fresh state then completes correctly in 16 cycles.
- Back-to-back streaming, out_ready=1, 100 random states vs software S-box model -> all match, period exactly PASSES+2 cycles.
